// File: rtl/tms34020_pkg.sv
// rtl/tms34020_pkg.sv - shared types and constants for the TMS34020 cache fill controller
package tms34020_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DACC,
    FILL_REQ,
    FILL_WR
  } fill_state_t;

  localparam int FILL_BEATS = 4;
  localparam int LWORD_LSB  = 5;
  localparam int SUBSEG_LSB = 7;

endpackage

// File: rtl/tms34020_mem_arb.sv
// rtl/tms34020_mem_arb.sv - two-way priority between CPU data access and cache fill
module tms34020_mem_arb #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic dreq,
  input  logic fill_want,
  output logic grant_data,
  output logic grant_fill
);

  always_comb begin
    grant_data = dreq && (DATA_FIRST || !fill_want);
    grant_fill = fill_want && (!DATA_FIRST || !dreq);
  end

endmodule

// File: rtl/tms34020_cache_fill_ctrl.sv
// rtl/tms34020_cache_fill_ctrl.sv - cache subsegment fill sequencer and memory port arbiter
module tms34020_cache_fill_ctrl
  import tms34020_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          EN,
  input  logic          CE_F,
  input  logic          CE_R,
  input  logic          RES_N,
  input  logic          CACHE_DIS,
  input  logic          CACHE_MISS,
  input  logic [AW-1:0] PC,
  output logic [DW-1:0] CACHE_DATA,
  output logic          CACHE_WR,
  output logic          FILL_BUSY,
  input  logic          DREQ,
  input  logic          DWE,
  input  logic [AW-1:0] DADDR,
  input  logic [DW-1:0] DWDATA,
  output logic          DACK,
  output logic [DW-1:0] DRDATA,
  output logic          MEM_REQ,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic          MEM_ACK,
  input  logic [DW-1:0] MEM_RDATA
);

  localparam logic [LWORD_LSB-1:0] LW_ZERO = '0;

  fill_state_t              state_q, state_d;
  logic [1:0]               beat_q, beat_d;
  logic [1:0]               sidx_q, sidx_d;
  logic [AW-1:SUBSEG_LSB]   base_q, base_d;
  logic [1:0]               next_idx;
  logic                     last_beat;
  logic                     fill_want, grant_data, grant_fill, tick;

  logic                     mem_req_d, mem_we_d, cache_wr_d, fill_busy_d, dack_d;
  logic [AW-1:0]            mem_addr_d;
  logic [DW-1:0]            mem_wdata_d, cache_data_d, drdata_d;

  // CE_F only clocks the cache RAM; sub-longword address bits never reach the bus.
  logic unused_inputs;
  assign unused_inputs = ^{CE_F, PC[LWORD_LSB-1:0], DADDR[LWORD_LSB-1:0]};

  assign tick      = EN && CE_R;
  assign fill_want = CACHE_MISS && !CACHE_DIS;
  assign last_beat = (beat_q == 2'(FILL_BEATS - 1));
  assign next_idx  = sidx_q + beat_q + 2'd1;

  tms34020_mem_arb #(.DATA_FIRST(DATA_FIRST)) u_arb (
    .dreq      (DREQ),
    .fill_want (fill_want),
    .grant_data(grant_data),
    .grant_fill(grant_fill)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    state_q <= IDLE;
    else if (tick) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!RES_N) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (grant_data) state_d = DACC;
                  else if (grant_fill) state_d = FILL_REQ;
        DACC:     if (MEM_ACK) state_d = IDLE;
        FILL_REQ: if (MEM_ACK) state_d = FILL_WR;
        FILL_WR:  state_d = last_beat ? IDLE : FILL_REQ;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    beat_d       = beat_q;
    sidx_d       = sidx_q;
    base_d       = base_q;
    mem_req_d    = MEM_REQ;
    mem_we_d     = MEM_WE;
    mem_addr_d   = MEM_ADDR;
    mem_wdata_d  = MEM_WDATA;
    cache_data_d = CACHE_DATA;
    cache_wr_d   = 1'b0;
    fill_busy_d  = FILL_BUSY;
    dack_d       = 1'b0;
    drdata_d     = DRDATA;
    // Soft abort drops strobes and any acknowledge in flight; bus values are kept.
    if (!RES_N) begin
      mem_req_d   = 1'b0;
      fill_busy_d = 1'b0;
      beat_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_data) begin
            mem_req_d   = 1'b1;
            mem_we_d    = DWE;
            mem_addr_d  = {DADDR[AW-1:LWORD_LSB], LW_ZERO};
            mem_wdata_d = DWDATA;
          end else if (grant_fill) begin
            base_d      = PC[AW-1:SUBSEG_LSB];
            sidx_d      = PC[SUBSEG_LSB-1:LWORD_LSB];
            beat_d      = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = {PC[AW-1:LWORD_LSB], LW_ZERO};
            fill_busy_d = 1'b1;
          end
        end
        DACC: begin
          if (MEM_ACK) begin
            mem_req_d = 1'b0;
            dack_d    = 1'b1;
            if (!MEM_WE) drdata_d = MEM_RDATA;
          end
        end
        FILL_REQ: begin
          if (MEM_ACK) begin
            cache_data_d = MEM_RDATA;
            cache_wr_d   = 1'b1;
            mem_req_d    = 1'b0;
          end
        end
        FILL_WR: begin
          beat_d = beat_q + 2'd1;
          if (last_beat) begin
            fill_busy_d = 1'b0;
          end else begin
            // Beats wrap inside the subsegment; the base never advances.
            mem_req_d  = 1'b1;
            mem_addr_d = {base_q, next_idx, LW_ZERO};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      beat_q     <= '0;
      sidx_q     <= '0;
      base_q     <= '0;
      MEM_REQ    <= 1'b0;
      MEM_WE     <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_WDATA  <= '0;
      CACHE_DATA <= '0;
      CACHE_WR   <= 1'b0;
      FILL_BUSY  <= 1'b0;
      DACK       <= 1'b0;
      DRDATA     <= '0;
    end else if (tick) begin
      beat_q     <= beat_d;
      sidx_q     <= sidx_d;
      base_q     <= base_d;
      MEM_REQ    <= mem_req_d;
      MEM_WE     <= mem_we_d;
      MEM_ADDR   <= mem_addr_d;
      MEM_WDATA  <= mem_wdata_d;
      CACHE_DATA <= cache_data_d;
      CACHE_WR   <= cache_wr_d;
      FILL_BUSY  <= fill_busy_d;
      DACK       <= dack_d;
      DRDATA     <= drdata_d;
    end
  end

endmodule
